basys2_display_scan: RTL and testbench
======================================

# basys2_display_scan

Multiplexed driver for the Basys2 four-digit seven-segment display. It is the output-side counterpart to the board top, which currently ties `seg`, `dp` and `an` to constants. The block accepts a 16-bit hex value, four decimal-point bits and a leading-zero-blank flag through a load strobe. It scans the digits time-multiplexed with a short anode-off guard interval, and updates the displayed value only at frame boundaries so a digit never tears.

## Interface
- `DIGIT_CYCLES`, 50000: mclk cycles per digit slot (1 ms at 50 MHz); legal range ≥ `BLANK_CYCLES`+2.
- `BLANK_CYCLES`, 500: cycles at the start of each slot with all anodes off (anti-ghosting); 0 is legal.
- `mclk` in 1: clock, all logic on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `load` in 1: single-cycle strobe; captures `number`, `dots`, `blank_zeros`.
- `number` in 16: four hex nibbles, [3:0] = rightmost digit (digit 0).
- `dots` in 4: decimal point per digit, 1 = lit, bit i ↔ digit i.
- `blank_zeros` in 1: 1 = suppress leading zero digits.
- `seg` out 7: segments g..a (seg[0]=a … seg[6]=g), active-low, registered.
- `dp` out 1: decimal point, active-low, registered.
- `an` out 4: anodes, active-low, an[i] ↔ digit i, registered.
- `frame_start` out 1: one-cycle pulse when the scan enters digit 0.

## Operation
- Slot counter `cnt` runs 0..`DIGIT_CYCLES`-1. On wrap, digit index `idx` advances 0→1→2→3→0.
- Shadow register holds the latest `load` data plus a `pending` flag. Multiple loads in one frame: last wins.
- Frame boundary is the cycle where `idx` wraps 3→0. If `pending`, the display register takes the shadow and `pending` clears.
- `load` in the boundary cycle is bypassed: the display register takes the new inputs directly and `pending` stays 0.
- Blanking: with `blank_zeros`=1, digit 3 is blank if nibble3 = 0. Digit 2 is blank if nibbles 3..2 = 0. Digit 1 is blank if nibbles 3..1 = 0. Digit 0 is never blanked.
- A blank digit drives `seg`=7'h7F. Its `dp` still follows the corresponding dot bit.
- Hex decode (active-low g..a): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
- Guard interval: while `cnt` < `BLANK_CYCLES`, `an`=4'hF. Otherwise `an` = ~(1<<idx).

## Timing
- Reset values: `seg`=7'h7F, `dp`=1, `an`=4'hF, `frame_start`=0, `cnt`=0, `idx`=0, display register = 0, `dots`=0, `blank_zeros`=0, `pending`=0.
- Display after reset: "0000" with no blanking.
- All outputs are registered. They reflect the `cnt`/`idx` state of the previous cycle, giving one cycle of latency.
- First anode enables on cycle `BLANK_CYCLES`+1 after reset release.
- `frame_start` is asserted in the first cycle that `idx`=0 is visible on outputs, i.e. same cycle as the first `an`=4'hF of the digit-0 slot.
- Load-to-display latency is at most 4·`DIGIT_CYCLES`+1 cycles.
- Reset mid-frame aborts immediately: outputs go to reset values asynchronously and any pending load is discarded.

## Structure
- Shared package `basys2_display_pkg` holds:
  - `SEG_BLANK` = 7'h7F;
  - the 16-entry segment pattern constants;
  - `AN_OFF` = 4'hF;
  - a `digit_idx_t` 2-bit typedef.
- One combinational sub-module, `hex_to_seg7` (4-bit in, 7-bit active-low out), is instantiated once on the muxed nibble.

## Test plan
Run with `DIGIT_CYCLES`=8, `BLANK_CYCLES`=2.
- Reset: assert `reset_n`=0 mid-slot → `seg`=7F, `dp`=1, `an`=F the same cycle. Release → first `an`=E three cycles later, with `seg`=40.
- Scan order: load 16'h1234, `dots`=4'b0101 → next frame shows an=E/seg=19/dp=0, an=D/seg=30/dp=1, an=B/seg=24/dp=0, an=7/seg=79/dp=1. Each slot has 2 cycles of `an`=F.
- Leading zeros: load 16'h0070, `blank_zeros`=1 → digits 3 and 2 show `seg`=7F; digit 1 shows 78, digit 0 shows 40. Load 16'h0000 → only digit 0 is lit, `seg`=40.
- No tearing: load 16'hAAAA, then 16'hBBBB and 16'hCCCC within one frame, during digit 1 → digits 1..3 keep showing the old value. The next frame shows C on all digits (`seg`=46).
- Boundary bypass: `load` 16'hFFFF exactly in the idx 3→0 cycle → following frame shows `seg`=0E on all digits and `pending` stays 0.
- `frame_start` check: the pulse occurs every 32 cycles and coincides with the digit-0 guard interval.

Source files
------------

// File: rtl/basys2_display_pkg.sv
// Shared constants and types for the Basys2 seven-segment scan driver.
// Segment patterns are active-low, bit order g..a (bit 0 = segment a).
package basys2_display_pkg;

    typedef logic [1:0] digit_idx_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] AN_OFF    = 4'hF;

    // Element [n] is the pattern for hex digit n.
    localparam logic [15:0][6:0] SEG_HEX = {
        7'h0E, 7'h06, 7'h21, 7'h46,
        7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19,
        7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/basys2_display_scan_hex.sv
// hex_to_seg7: combinational hex digit to active-low seven-segment decoder.
// Ports: hex_i (4-bit digit), seg_o (7-bit pattern g..a, active-low).
module hex_to_seg7
    import basys2_display_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG_HEX[hex_i];

endmodule

// File: rtl/basys2_display_scan.sv
// basys2_display_scan: four-digit multiplexed seven-segment driver with
// anode guard interval, leading-zero blanking and frame-aligned updates.
// Ports: mclk, reset_n (async, active-low), load strobe with number/dots/
// blank_zeros; registered active-low seg/dp/an outputs and frame_start.
module basys2_display_scan
    import basys2_display_pkg::*;
#(
    parameter int DIGIT_CYCLES = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic        mclk,
    input  logic        reset_n,
    input  logic        load,
    input  logic [15:0] number,
    input  logic [3:0]  dots,
    input  logic        blank_zeros,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic        frame_start
);

    localparam int CW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIGIT_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    digit_idx_t    idx_q, idx_d;

    // Shadow (written by load) and display (used by the scan) copies.
    logic [15:0] sh_num_q, sh_num_d, dsp_num_q, dsp_num_d;
    logic [3:0]  sh_dot_q, sh_dot_d, dsp_dot_q, dsp_dot_d;
    logic        sh_bz_q, sh_bz_d, dsp_bz_q, dsp_bz_d;
    logic        pend_q, pend_d;

    logic [6:0] seg_q, seg_d;
    logic       dp_q, dp_d;
    logic [3:0] an_q, an_d;
    logic       fs_q, fs_d;

    logic        slot_end;
    logic        frame_end;
    logic [15:0] upper;
    logic [6:0]  hex_seg;
    logic        blank;
    logic        guard;

    assign slot_end  = (cnt_q == CNT_LAST);
    assign frame_end = slot_end && (idx_q == 2'd3);

    // Current digit and everything to its left; zero means leading zero.
    assign upper = dsp_num_q >> {idx_q, 2'b00};
    assign blank = dsp_bz_q && (idx_q != 2'd0) && (upper == 16'h0000);
    assign guard = int'(cnt_q) < BLANK_CYCLES;

    hex_to_seg7 u_dec (
        .hex_i (upper[3:0]),
        .seg_o (hex_seg)
    );

    always_comb begin
        cnt_d     = slot_end ? '0 : cnt_q + CW'(1);
        idx_d     = slot_end ? digit_idx_t'(idx_q + 2'd1) : idx_q;
        sh_num_d  = sh_num_q;
        sh_dot_d  = sh_dot_q;
        sh_bz_d   = sh_bz_q;
        dsp_num_d = dsp_num_q;
        dsp_dot_d = dsp_dot_q;
        dsp_bz_d  = dsp_bz_q;
        pend_d    = pend_q;
        if (frame_end) begin
            // A load on the boundary cycle bypasses the shadow.
            if (load) begin
                dsp_num_d = number;
                dsp_dot_d = dots;
                dsp_bz_d  = blank_zeros;
            end else if (pend_q) begin
                dsp_num_d = sh_num_q;
                dsp_dot_d = sh_dot_q;
                dsp_bz_d  = sh_bz_q;
            end
            pend_d = 1'b0;
        end else if (load) begin
            sh_num_d = number;
            sh_dot_d = dots;
            sh_bz_d  = blank_zeros;
            pend_d   = 1'b1;
        end
    end

    always_comb begin
        seg_d = blank ? SEG_BLANK : hex_seg;
        dp_d  = ~dsp_dot_q[idx_q];
        an_d  = guard ? AN_OFF : ~(4'b0001 << idx_q);
        fs_d  = (cnt_q == '0) && (idx_q == 2'd0);
    end

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            idx_q     <= '0;
            sh_num_q  <= '0;
            sh_dot_q  <= '0;
            sh_bz_q   <= 1'b0;
            dsp_num_q <= '0;
            dsp_dot_q <= '0;
            dsp_bz_q  <= 1'b0;
            pend_q    <= 1'b0;
            seg_q     <= SEG_BLANK;
            dp_q      <= 1'b1;
            an_q      <= AN_OFF;
            fs_q      <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            sh_num_q  <= sh_num_d;
            sh_dot_q  <= sh_dot_d;
            sh_bz_q   <= sh_bz_d;
            dsp_num_q <= dsp_num_d;
            dsp_dot_q <= dsp_dot_d;
            dsp_bz_q  <= dsp_bz_d;
            pend_q    <= pend_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
            an_q      <= an_d;
            fs_q      <= fs_d;
        end
    end

    assign seg         = seg_q;
    assign dp          = dp_q;
    assign an          = an_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_basys2_display_scan.sv
// Testbench for basys2_display_scan: random and directed loads, per-cycle
// expected outputs from a frame-level model, checked by a scoreboard.
module tb_basys2_display_scan;

    localparam int DC = 8;
    localparam int BC = 2;
    localparam int FR = 4 * DC;

    logic        mclk = 1'b0;
    logic        reset_n = 1'b0;
    logic        load = 1'b0;
    logic [15:0] number = '0;
    logic [3:0]  dots = '0;
    logic        blank_zeros = 1'b0;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_start;

    basys2_display_scan #(
        .DIGIT_CYCLES (DC),
        .BLANK_CYCLES (BC)
    ) dut (
        .mclk        (mclk),
        .reset_n     (reset_n),
        .load        (load),
        .number      (number),
        .dots        (dots),
        .blank_zeros (blank_zeros),
        .seg         (seg),
        .dp          (dp),
        .an          (an),
        .frame_start (frame_start)
    );

    always #5 mclk = ~mclk;

    typedef struct {
        logic [6:0] seg;
        logic       dp;
        logic [3:0] an;
        logic       fs;
    } exp_t;

    exp_t q[$];
    int vectors = 0;
    int errors  = 0;

    logic [6:0] hexlut [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Model: t = scan positions elapsed since reset release. A frame shows
    // whatever was loaded last before the frame began.
    int          t = 0;
    logic [15:0] l_num, s_num;
    logic [3:0]  l_dot, s_dot;
    logic        l_bz, s_bz;

    always @(posedge mclk or negedge reset_n) begin
        int p, pos, d, c;
        logic [15:0] up;
        exp_t e;
        if (!reset_n) begin
            t = 0;
            l_num = '0; l_dot = '0; l_bz = 1'b0;
            s_num = '0; s_dot = '0; s_bz = 1'b0;
            q.delete();
        end else begin
            p = t;
            t++;
            pos = p % FR;
            d = pos / DC;
            c = pos % DC;
            if (pos == 0) begin
                s_num = l_num; s_dot = l_dot; s_bz = l_bz;
            end
            up = s_num >> (4 * d);
            e.seg = (s_bz && d > 0 && up == 16'h0) ? 7'h7F : hexlut[up[3:0]];
            e.dp  = !s_dot[d];
            e.an  = (c < BC) ? 4'hF : (4'hF ^ (4'(1) << d));
            e.fs  = (pos == 0);
            q.push_back(e);
            if (load) begin
                l_num = number; l_dot = dots; l_bz = blank_zeros;
            end
        end
    end

    always @(negedge mclk) begin
        exp_t e;
        if (!reset_n) begin
            vectors++;
            if (seg !== 7'h7F || dp !== 1'b1 || an !== 4'hF
                || frame_start !== 1'b0) begin
                errors++;
                $display("FAIL in_reset: got seg=%h dp=%b an=%h fs=%b want 7f 1 f 0",
                         seg, dp, an, frame_start);
            end
        end else if (q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty at t=%0d", t);
        end else begin
            e = q.pop_front();
            vectors++;
            if (seg !== e.seg || dp !== e.dp || an !== e.an
                || frame_start !== e.fs) begin
                errors++;
                $display("FAIL scan t=%0d: got seg=%h dp=%b an=%h fs=%b want seg=%h dp=%b an=%h fs=%b",
                         t, seg, dp, an, frame_start, e.seg, e.dp, e.an, e.fs);
            end
        end
    end

    // All tasks start and end at 1 time unit after a falling edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(negedge mclk);
            #1;
        end
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d,
                           input logic bz);
        load = 1'b1;
        number = v;
        dots = d;
        blank_zeros = bz;
        tick(1);
        load = 1'b0;
        number = 16'($urandom);
        dots = 4'($urandom);
        blank_zeros = 1'($urandom);
    endtask

    // Wait until the next rising edge samples frame position tgt.
    task automatic wait_pos(input int tgt);
        int n = 0;
        while ((t % FR) != tgt && n < 4 * FR) begin
            tick(1);
            n++;
        end
        if (n >= 4 * FR) begin
            errors++;
            $display("FAIL wait_pos timeout: got pos=%0d want %0d", t % FR, tgt);
        end
    endtask

    task automatic mid_reset();
        #2;
        reset_n = 1'b0;
        #1;
        vectors++;
        if (seg !== 7'h7F || dp !== 1'b1 || an !== 4'hF
            || frame_start !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got seg=%h dp=%b an=%h fs=%b want 7f 1 f 0",
                     seg, dp, an, frame_start);
        end
        tick(3);
        reset_n = 1'b1;
    endtask

    initial begin
        tick(3);
        reset_n = 1'b1;
        tick(2 * FR);

        do_load(16'h1234, 4'b0101, 1'b0);
        tick(2 * FR);

        do_load(16'h0070, 4'b0000, 1'b1);
        tick(2 * FR);
        do_load(16'h0000, 4'b0000, 1'b1);
        tick(2 * FR);

        wait_pos(0);
        do_load(16'hAAAA, 4'b0000, 1'b0);
        tick(FR);
        wait_pos(DC + 1);
        do_load(16'hBBBB, 4'b0000, 1'b0);
        do_load(16'hCCCC, 4'b0000, 1'b0);
        tick(2 * FR);

        wait_pos(FR - 1);
        do_load(16'hFFFF, 4'b1111, 1'b0);
        tick(2 * FR);

        tick(11);
        mid_reset();
        tick(FR + 5);

        for (int i = 0; i < 80; i++) begin
            if (($urandom % 5) == 0) wait_pos(FR - 1);
            else tick($urandom_range(0, 40));
            do_load(($urandom % 3 == 0) ? 16'($urandom % 256) : 16'($urandom),
                    4'($urandom), 1'($urandom));
            if (i == 40) mid_reset();
        end
        tick(2 * FR);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
